// File: rtl/corepwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : corepwm_capture
//  Description : Input capture for an external PWM signal. Measures period
//                and high time in prescaled PCLK ticks, flags saturation,
//                and strobes capture_valid on every completed measurement.
//  Revision    : 1.0  initial release
// ============================================================================
module corepwm_capture #(
    parameter int APB_DWIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  enable,
    input  logic [APB_DWIDTH-1:0] prescale_reg,
    input  logic                  clear_ovf,
    input  logic                  pwm_in,
    output logic [APB_DWIDTH-1:0] measured_period,
    output logic [APB_DWIDTH-1:0] measured_high,
    output logic                  capture_valid,
    output logic                  overflow,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_LOW  = 2'd3;

    localparam logic [APB_DWIDTH-1:0] C_MAX  = '1;
    localparam logic [APB_DWIDTH-1:0] C_ZERO = '0;
    localparam logic [APB_DWIDTH-1:0] C_ONE  = {{(APB_DWIDTH-1){1'b0}}, 1'b1};

    logic                  sync1_q, sync2_q, pwm_d_q;
    logic [1:0]            state_q, state_d;
    logic [APB_DWIDTH-1:0] presc_q, presc_d;
    logic [APB_DWIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [APB_DWIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [APB_DWIDTH-1:0] period_q, period_d;
    logic [APB_DWIDTH-1:0] high_q, high_d;
    logic                  cv_q, cv_d;
    logic                  ovf_q, ovf_d;

    logic                  w_rise, w_fall, w_tick, w_run, w_sat;
    logic [APB_DWIDTH-1:0] w_per_capture;

    assign w_rise = sync2_q & ~pwm_d_q;
    assign w_fall = ~sync2_q & pwm_d_q;
    assign w_tick = (presc_q >= prescale_reg);
    assign w_run  = (state_q == S_HIGH) || (state_q == S_LOW);
    // Saturation only counts when no rise arrives to close the period.
    assign w_sat  = w_run && w_tick && (per_cnt_q == C_MAX) && !w_rise;
    // A tick landing on the closing rise is part of the finished period,
    // but the result must not wrap past all-ones.
    assign w_per_capture = (per_cnt_q == C_MAX) ? C_MAX
                         : (w_tick ? per_cnt_q + C_ONE : per_cnt_q);

    // Synchronize the asynchronous input and keep a one-cycle delayed copy.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            pwm_d_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            pwm_d_q <= sync2_q;
        end
    end

    // Next-state logic: prescaler, measurement counters, FSM and results.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        cv_d      = 1'b0;
        ovf_d     = clear_ovf ? 1'b0 : ovf_q;

        if (!enable || (state_q == S_IDLE) || w_rise || w_tick) begin
            presc_d = C_ZERO;
        end else begin
            presc_d = presc_q + C_ONE;
        end

        if (!enable) begin
            state_d   = S_IDLE;
            per_cnt_d = C_ZERO;
            hi_cnt_d  = C_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_SYNC;
                    per_cnt_d = C_ZERO;
                    hi_cnt_d  = C_ZERO;
                end
                S_SYNC: begin
                    per_cnt_d = C_ZERO;
                    hi_cnt_d  = C_ZERO;
                    if (w_rise) begin
                        state_d = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_sat) begin
                        ovf_d     = 1'b1;
                        state_d   = S_SYNC;
                        per_cnt_d = C_ZERO;
                        hi_cnt_d  = C_ZERO;
                    end else begin
                        if (w_tick) begin
                            per_cnt_d = per_cnt_q + C_ONE;
                            hi_cnt_d  = hi_cnt_q + C_ONE;
                        end
                        if (w_fall) begin
                            state_d = S_LOW;
                        end
                    end
                end
                default: begin // S_LOW
                    if (w_rise) begin
                        period_d  = w_per_capture;
                        high_d    = hi_cnt_q;
                        cv_d      = 1'b1;
                        per_cnt_d = C_ZERO;
                        hi_cnt_d  = C_ZERO;
                        state_d   = S_HIGH;
                    end else if (w_sat) begin
                        ovf_d     = 1'b1;
                        state_d   = S_SYNC;
                        per_cnt_d = C_ZERO;
                        hi_cnt_d  = C_ZERO;
                    end else if (w_tick) begin
                        per_cnt_d = per_cnt_q + C_ONE;
                    end
                end
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= S_IDLE;
            presc_q   <= C_ZERO;
            per_cnt_q <= C_ZERO;
            hi_cnt_q  <= C_ZERO;
            period_q  <= C_ZERO;
            high_q    <= C_ZERO;
            cv_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            cv_q      <= cv_d;
            ovf_q     <= ovf_d;
        end
    end

    assign measured_period = period_q;
    assign measured_high   = high_q;
    assign capture_valid   = cv_q;
    assign overflow        = ovf_q;
    assign busy            = w_run;

endmodule
`default_nettype wire

// File: tb/tb_corepwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_corepwm_capture
//  Description : Self-checking bench for corepwm_capture: vector table,
//                hand-written corner sequences and randomized input against
//                a period/high-time reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_corepwm_capture;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] prescale_reg = 8'd0;
    logic       clear_ovf = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] measured_period, measured_high;
    logic       capture_valid, overflow, busy;

    int n_pass = 0;
    int n_tot  = 0;
    int cv_count = 0;

    corepwm_capture #(.APB_DWIDTH(8)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .enable(enable),
        .prescale_reg(prescale_reg), .clear_ovf(clear_ovf), .pwm_in(pwm_in),
        .measured_period(measured_period), .measured_high(measured_high),
        .capture_valid(capture_valid), .overflow(overflow), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Works on edge times: an acted-on rise/fall happens at a known cycle
    // index; period/high results are elapsed cycles divided by (prescale+1),
    // and saturation fires 256 ticks after the opening rise.
    logic m_s1 = 0, m_s2 = 0, m_d = 0;
    int   m_t = 0, m_mode = 0, m_last = 0, m_fall = 0, m_per = 0, m_hi = 0;
    bit   m_fell = 0, m_cv = 0, m_ovf = 0;
    logic m_rise, m_fallev;
    bit   m_new;
    int   m_p, m_n;

    always @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            m_s1 = 0; m_s2 = 0; m_d = 0;
            m_mode = 0; m_per = 0; m_hi = 0; m_cv = 0; m_ovf = 0; m_fell = 0;
        end else begin
            m_t++;
            m_rise   = m_s2 & ~m_d;
            m_fallev = ~m_s2 & m_d;
            m_new = 0;
            m_cv  = 0;
            m_p   = int'(prescale_reg) + 1;
            if (!enable) m_mode = 0;
            else if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1) begin
                if (m_rise) begin m_mode = 2; m_last = m_t; m_fell = 0; end
            end else begin
                if (m_rise && m_fell) begin
                    m_n   = m_t - m_last;
                    m_per = (m_n / m_p > 255) ? 255 : m_n / m_p;
                    m_hi  = (m_fall - m_last) / m_p;
                    m_cv  = 1;
                    m_last = m_t;
                    m_fell = 0;
                end else if (m_t - m_last == 256 * m_p) begin
                    m_new  = 1;
                    m_mode = 1;
                end else if (m_fallev && !m_fell) begin
                    m_fell = 1;
                    m_fall = m_t;
                end
            end
            if (clear_ovf) m_ovf = 0;
            if (m_new) m_ovf = 1;
            m_d = m_s2; m_s2 = m_s1; m_s1 = pwm_in;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge PCLK) begin
        chk("model_period", measured_period, m_per);
        chk("model_high", measured_high, m_hi);
        chk("model_cv", capture_valid, m_cv);
        chk("model_ovf", overflow, m_ovf);
        chk("model_busy", busy, (m_mode == 2) ? 1 : 0);
        if (capture_valid) cv_count++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge PCLK); #2; end
    endtask

    task automatic pulse(input int hi, input int lo);
        pwm_in = 1'b1; step(hi);
        pwm_in = 1'b0; step(lo);
    endtask

    task automatic restart(input int p);
        enable = 1'b0; pwm_in = 1'b0; step(4);
        prescale_reg = 8'(p);
        clear_ovf = 1'b1; step(1); clear_ovf = 1'b0;
        enable = 1'b1; step(2);
    endtask

    typedef struct {
        int p; int hi; int lo; int exp_per; int exp_hi;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int base, prev, r, hi, lo;

        vecs[0] = '{0, 25, 75, 100, 25};
        vecs[1] = '{3, 25, 75, 25, 6};
        vecs[2] = '{1, 10, 40, 25, 5};
        vecs[3] = '{7, 32, 32, 8, 4};
        vecs[4] = '{0, 100, 156, 255, 100};  // rise on the saturating tick
        vecs[5] = '{0, 1, 254, 255, 1};
        vecs[6] = '{2, 5, 5, 3, 1};

        // reset state
        #1;
        chk("rst_period", measured_period, 0);
        chk("rst_high", measured_high, 0);
        chk("rst_cv", capture_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        step(2);
        PRESETN = 1'b1;
        step(2);

        // table-driven vectors
        foreach (vecs[i]) begin
            restart(vecs[i].p);
            repeat (3) pulse(vecs[i].hi, vecs[i].lo);
            pwm_in = 1'b1; step(5);
            chk($sformatf("vec%0d_period", i), measured_period, vecs[i].exp_per);
            chk($sformatf("vec%0d_high", i), measured_high, vecs[i].exp_hi);
            chk($sformatf("vec%0d_ovf", i), overflow, 0);
        end

        // stuck-low input after a rise -> saturation
        restart(0);
        prev = measured_period;
        base = cv_count;
        pulse(3, 1);
        for (int i = 0; i < 400 && !overflow; i++) step(1);
        chk("stuck_low_ovf", overflow, 1);
        chk("stuck_low_busy", busy, 0);
        chk("stuck_low_no_cv", cv_count - base, 0);
        chk("stuck_low_held", measured_period, prev);
        clear_ovf = 1'b1; step(1); clear_ovf = 1'b0;
        step(1);
        chk("clear_ovf", overflow, 0);

        // enable dropped mid-HIGH, then re-enabled
        restart(0);
        repeat (3) pulse(20, 20);
        pwm_in = 1'b1; step(10);
        enable = 1'b0; step(5);
        enable = 1'b1;
        base = cv_count;
        step(10); pwm_in = 1'b0; step(20);
        pulse(30, 30);
        chk("reen_no_cv", cv_count - base, 0);
        chk("reen_held_period", measured_period, 40);
        chk("reen_held_high", measured_high, 20);
        pwm_in = 1'b1; step(5);
        chk("reen_cv", cv_count - base, 1);
        chk("reen_period", measured_period, 60);
        chk("reen_high", measured_high, 30);

        // randomized stimulus against the model
        for (int seg = 0; seg < 20; seg++) begin
            enable = 1'b0; pwm_in = 1'b0; step(3);
            prescale_reg = 8'($urandom_range(0, 3));
            enable = 1'b1; step(2);
            for (int k = 0; k < 6; k++) begin
                r  = $urandom_range(0, 9);
                hi = (r == 3) ? $urandom_range(900, 1100) : $urandom_range(1, 60);
                lo = (r == 0) ? $urandom_range(900, 1100) : $urandom_range(1, 60);
                if (r == 1) begin clear_ovf = 1'b1; step(1); clear_ovf = 1'b0; end
                if (r == 2) begin enable = 1'b0; step($urandom_range(1, 3)); enable = 1'b1; end
                pulse(hi, lo);
            end
        end

        // asynchronous reset mid-measurement
        restart(0);
        pulse(20, 20);
        pwm_in = 1'b1; step(10);
        PRESETN = 1'b0;
        #1;
        chk("arst_period", measured_period, 0);
        chk("arst_high", measured_high, 0);
        chk("arst_cv", capture_valid, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_busy", busy, 0);
        step(2);
        PRESETN = 1'b1;
        pwm_in = 1'b0;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
